// File: rtl/mb_io_slave_regs_pkg.sv
// Shared types and constants for the MicroBlaze IO-bus register slave.
// Holds the FSM state encoding, the register-map offsets above NUM_REGS and the byte-lane helpers.
package mb_io_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  // Offsets of the extra map entries, counted from index NUM_REGS.
  localparam int STATUS_OFS   = 0;
  localparam int IRQ_STAT_OFS = 1;
  localparam int IRQ_EN_OFS   = 2;

  function automatic logic [31:0] lane_mask(input logic [NUM_LANES-1:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      m[i*LANE_W +: LANE_W] = {LANE_W{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mb_io_byte_reg.sv
// 32-bit register with independent byte-lane write enables and a parameterised reset value.
// Updates on the clock edge where a lane enable is high; no backpressure, always accepts.
module mb_io_byte_reg
  import mb_io_slave_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [31:0]          wr_data,
  output logic [31:0]          q
);

  logic [31:0] wmask;

  assign wmask = lane_mask(lane_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VALUE;
    end else begin
      q <= (q & ~wmask) | (wr_data & wmask);
    end
  end

endmodule

// File: rtl/mb_io_slave_regs.sv
// MicroBlaze IO-bus register slave: NUM_REGS r/w regs, one status word, optional IRQ block (MB_IO_SLAVE_REGS_IRQ_EN).
// IO_Ready pulses WAIT_STATES+1 cycles after the strobe; strobes outside IDLE are dropped rather than stalled.
module mb_io_slave_regs
  import mb_io_slave_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          ADDR_WIDTH  = 9,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   IO_Addr_Strobe,
  input  logic                   IO_Read_Strobe,
  input  logic                   IO_Write_Strobe,
  input  logic [ADDR_WIDTH-1:0]  IO_Address,
  input  logic [3:0]             IO_Byte_Enable,
  input  logic [31:0]            IO_Write_Data,
  output logic [31:0]            IO_Read_Data,
  output logic                   IO_Ready,
  output logic                   io_error,
  input  logic [31:0]            status_in,
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
  input  logic [31:0]            irq_src,
  output logic                   irq,
`endif
  output logic [NUM_REGS*32-1:0] regs_out
);

  localparam int          IDX_W     = ADDR_WIDTH - 2;
  localparam logic [31:0] STAT_IDX  = 32'(NUM_REGS + STATUS_OFS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] cap_idx;
  logic [3:0]       cap_be;
  logic [31:0]      cap_wdata;
  logic             cap_wr;
  logic             cap_both;

  logic             idle;
  logic             req;
  logic             enter_resp;
  logic             wr_commit;
  logic [31:0]      eff_idx;
  logic             eff_wr;
  logic             eff_both;
  logic             hit_rw;
  logic             hit_stat;
  logic             readable;
  logic             writable;
  logic             acc_err;
  logic [31:0]      rd_val;
  logic [31:0]      regs_q  [NUM_REGS];
  logic [3:0]       lane_en [NUM_REGS];
  logic             unused_addr_lsb;

`ifdef MB_IO_SLAVE_REGS_IRQ_EN
  localparam logic [31:0] ISTAT_IDX = 32'(NUM_REGS + IRQ_STAT_OFS);
  localparam logic [31:0] IEN_IDX   = 32'(NUM_REGS + IRQ_EN_OFS);

  logic        hit_istat;
  logic        hit_ien;
  logic [31:0] irq_stat;
  logic [31:0] irq_en_q;
  logic [31:0] irq_clr;
`endif

  assign unused_addr_lsb = ^IO_Address[1:0];
  assign idle            = (state == ST_IDLE);
  assign req             = IO_Addr_Strobe & (IO_Read_Strobe | IO_Write_Strobe);

  // In IDLE the live bus is decoded so a zero-wait access can respond next cycle;
  // afterwards the captured copy is used and later bus activity is ignored.
  assign eff_idx    = 32'(idle ? IO_Address[ADDR_WIDTH-1:2] : cap_idx);
  assign eff_wr     = idle ? IO_Write_Strobe : cap_wr;
  assign eff_both   = idle ? (IO_Read_Strobe & IO_Write_Strobe) : cap_both;
  assign enter_resp = (idle && req && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign wr_commit  = (state == ST_RESP) && cap_wr;

  always_comb begin
    hit_rw   = eff_idx < 32'(NUM_REGS);
    hit_stat = eff_idx == STAT_IDX;
    rd_val   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (eff_idx == 32'(i)) rd_val = regs_q[i];
    end
    if (hit_stat) rd_val = status_in;
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
    hit_istat = eff_idx == ISTAT_IDX;
    hit_ien   = eff_idx == IEN_IDX;
    if (hit_istat) rd_val = irq_stat;
    if (hit_ien)   rd_val = irq_en_q;
    readable = hit_rw | hit_stat | hit_istat | hit_ien;
    writable = hit_rw | hit_istat | hit_ien;
`else
    readable = hit_rw | hit_stat;
    writable = hit_rw;
`endif
    acc_err = eff_wr ? (!writable || eff_both) : !readable;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      lane_en[i] = (wr_commit && (eff_idx == 32'(i))) ? cap_be : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      cap_idx      <= '0;
      cap_be       <= 4'b0000;
      cap_wdata    <= 32'h0;
      cap_wr       <= 1'b0;
      cap_both     <= 1'b0;
      IO_Ready     <= 1'b0;
      io_error     <= 1'b0;
      IO_Read_Data <= 32'h0;
    end else begin
      IO_Ready <= 1'b0;
      io_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            cap_idx   <= IO_Address[ADDR_WIDTH-1:2];
            cap_be    <= IO_Byte_Enable;
            cap_wdata <= IO_Write_Data;
            cap_wr    <= IO_Write_Strobe;
            cap_both  <= IO_Read_Strobe & IO_Write_Strobe;
            if (WAIT_STATES == 0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        IO_Ready <= 1'b1;
        io_error <= acc_err;
        if (!eff_wr) IO_Read_Data <= rd_val;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    mb_io_byte_reg #(
      .RESET_VALUE(RESET_VALUE)
    ) u_reg (
      .clk    (clk),
      .reset_n(reset_n),
      .lane_en(lane_en[g]),
      .wr_data(cap_wdata),
      .q      (regs_q[g])
    );
    assign regs_out[g*32 +: 32] = regs_q[g];
  end

`ifdef MB_IO_SLAVE_REGS_IRQ_EN
  assign irq_clr = (wr_commit && hit_istat) ? (cap_wdata & lane_mask(cap_be)) : 32'h0;

  mb_io_byte_reg #(
    .RESET_VALUE(32'h0)
  ) u_irq_en (
    .clk    (clk),
    .reset_n(reset_n),
    .lane_en((wr_commit && hit_ien) ? cap_be : 4'b0000),
    .wr_data(cap_wdata),
    .q      (irq_en_q)
  );

  // Sources are OR-ed in after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_stat <= 32'h0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~irq_clr) | irq_src;
      irq      <= |(irq_stat & irq_en_q);
    end
  end
`endif

endmodule

// File: tb/tb_mb_io_slave_regs.sv
// Bench for mb_io_slave_regs: a zero-wait and a three-wait instance checked against an array model of the register map.
module tb_mb_io_slave_regs;

  localparam logic [31:0] RV = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        as_s [2];
  logic        rd_s [2];
  logic        wr_s [2];
  logic [8:0]  addr [2];
  logic [3:0]  be   [2];
  logic [31:0] wdat [2];
  logic [31:0] status [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        err  [2];
  logic [255:0] regs_o [2];
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
  logic [31:0] irq_src [2];
  logic        irq [2];
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mdl [2][8];
  logic [31:0] last_rd [2];
  logic [31:0] istat [2];
  logic [31:0] ien [2];

  always #5 clk = ~clk;

  mb_io_slave_regs #(.NUM_REGS(8), .ADDR_WIDTH(9), .WAIT_STATES(0), .RESET_VALUE(RV)) dut0 (
    .clk(clk), .reset_n(reset_n), .IO_Addr_Strobe(as_s[0]), .IO_Read_Strobe(rd_s[0]),
    .IO_Write_Strobe(wr_s[0]), .IO_Address(addr[0]), .IO_Byte_Enable(be[0]),
    .IO_Write_Data(wdat[0]), .IO_Read_Data(rdat[0]), .IO_Ready(rdy[0]), .io_error(err[0]),
    .status_in(status[0]),
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
    .irq_src(irq_src[0]), .irq(irq[0]),
`endif
    .regs_out(regs_o[0]));

  mb_io_slave_regs #(.NUM_REGS(8), .ADDR_WIDTH(9), .WAIT_STATES(3), .RESET_VALUE(RV)) dut3 (
    .clk(clk), .reset_n(reset_n), .IO_Addr_Strobe(as_s[1]), .IO_Read_Strobe(rd_s[1]),
    .IO_Write_Strobe(wr_s[1]), .IO_Address(addr[1]), .IO_Byte_Enable(be[1]),
    .IO_Write_Data(wdat[1]), .IO_Read_Data(rdat[1]), .IO_Ready(rdy[1]), .io_error(err[1]),
    .status_in(status[1]),
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
    .irq_src(irq_src[1]), .irq(irq[1]),
`endif
    .regs_out(regs_o[1]));

  // ---------------- reference model ----------------
  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = b[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [255:0] exp_regs(input int d);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = mdl[d][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) mdl[d][i] = RV;
      last_rd[d] = 32'h0;
      istat[d]   = 32'h0;
      ien[d]     = 32'h0;
    end
  endtask

  task automatic ref_read(input int d, input logic [8:0] a, output logic [31:0] v, output bit e);
    int idx;
    idx = int'(a[8:2]);
    v = 32'h0;
    e = 1'b1;
    if (idx < 8) begin
      v = mdl[d][idx]; e = 1'b0;
    end else if (idx == 8) begin
      v = status[d]; e = 1'b0;
    end
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
    else if (idx == 9) begin
      v = istat[d]; e = 1'b0;
    end else if (idx == 10) begin
      v = ien[d]; e = 1'b0;
    end
`endif
  endtask

  task automatic ref_write(input int d, input logic [8:0] a, input logic [3:0] b,
                           input logic [31:0] wd, input bit both, output bit e);
    int idx;
    logic [31:0] m;
    idx = int'(a[8:2]);
    m = bmask(b);
    e = 1'b1;
    if (idx < 8) begin
      mdl[d][idx] = (mdl[d][idx] & ~m) | (wd & m); e = both;
    end
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
    else if (idx == 9) begin
      istat[d] = istat[d] & ~(wd & m); e = both;
    end else if (idx == 10) begin
      ien[d] = (ien[d] & ~m) | (wd & m); e = both;
    end
`endif
  endtask

  // Runs one bus transaction starting just after a rising edge; bus inputs are scrambled
  // after the strobe cycle. Returns one cycle after the response, with the DUT idle again.
  task automatic access(input int d, input bit r, input bit w, input logic [8:0] a,
                        input logic [3:0] b, input logic [31:0] wd,
                        output logic [31:0] v, output bit e, output int lat);
    as_s[d] = 1'b1; rd_s[d] = r; wr_s[d] = w; addr[d] = a; be[d] = b; wdat[d] = wd;
    @(posedge clk); #1;
    as_s[d] = 1'b0; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    addr[d] = 9'($urandom); be[d] = 4'($urandom); wdat[d] = $urandom;
    lat = 1;
    while (!rdy[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rdy[d]) lat = -1;
    v = rdat[d];
    e = err[d];
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (rdy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b want 0", d, rdy[d]); end
      n_cmp++; if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_error dut%0d: got %b want 0", d, err[d]); end
      n_cmp++; if (rdat[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdat[d]); end
      n_cmp++; if (regs_o[d] !== exp_regs(d)) begin n_fail++; $display("FAIL reset_regs dut%0d: got %h want %h", d, regs_o[d], exp_regs(d)); end
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
      n_cmp++; if (irq[d] !== 1'b0) begin n_fail++; $display("FAIL reset_irq dut%0d: got %b want 0", d, irq[d]); end
`endif
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] v; bit e, xe; int lat;
    access(0, 0, 1, 9'h004, 4'hF, 32'hDEADBEEF, v, e, lat);
    ref_write(0, 9'h004, 4'hF, 32'hDEADBEEF, 0, xe);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL basic_wr_latency: got %0d want 1", lat); end
    n_cmp++; if (e !== xe) begin n_fail++; $display("FAIL basic_wr_error: got %b want %b", e, xe); end
    access(0, 1, 0, 9'h004, 4'h0, 32'h0, v, e, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL basic_rd_latency: got %0d want 1", lat); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_rd_error: got %b want 0", e); end
    n_cmp++; if (v !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data: got %h want deadbeef", v); end
    last_rd[0] = 32'hDEADBEEF;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] v, wd; bit e, xe; int lat;
    access(0, 0, 1, 9'h008, 4'hF, 32'hFFFFFFFF, v, e, lat);
    ref_write(0, 9'h008, 4'hF, 32'hFFFFFFFF, 0, xe);
    access(0, 0, 1, 9'h008, 4'b0101, 32'h11223344, v, e, lat);
    ref_write(0, 9'h008, 4'b0101, 32'h11223344, 0, xe);
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL lanes_wr_error: got %b want 0", e); end
    access(0, 1, 0, 9'h008, 4'h0, 32'h0, v, e, lat);
    n_cmp++; if (v !== 32'hFF22FF44) begin n_fail++; $display("FAIL lanes_rd_data: got %h want ff22ff44", v); end
    wd = $urandom;
    access(0, 0, 1, 9'h008, 4'b0000, wd, v, e, lat);
    ref_write(0, 9'h008, 4'b0000, wd, 0, xe);
    n_cmp++; if (e !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL lanes_be0: got err %b lat %0d want err 0 lat 1", e, lat); end
    access(0, 1, 0, 9'h008, 4'h0, 32'h0, v, e, lat);
    n_cmp++; if (v !== 32'hFF22FF44) begin n_fail++; $display("FAIL lanes_be0_data: got %h want ff22ff44", v); end
    last_rd[0] = 32'hFF22FF44;
  endtask

  task automatic test_map();
    logic [31:0] v, xv; bit e, xe; int lat;
    status[0] = $urandom;
    access(0, 1, 0, 9'h020, 4'h0, 32'h0, v, e, lat);
    n_cmp++; if (v !== status[0] || e !== 1'b0) begin n_fail++; $display("FAIL map_status_rd: got %h/%b want %h/0", v, e, status[0]); end
    last_rd[0] = status[0];
    access(0, 0, 1, 9'h020, 4'hF, $urandom, v, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL map_status_wr_error: got %b want 1", e); end
    n_cmp++; if (v !== last_rd[0]) begin n_fail++; $display("FAIL map_rdata_hold: got %h want %h", v, last_rd[0]); end
    access(0, 1, 0, 9'h040, 4'h0, 32'h0, v, e, lat);
    n_cmp++; if (v !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL map_unmapped_rd: got %h/%b want 0/1", v, e); end
    last_rd[0] = 32'h0;
    access(0, 0, 1, 9'h044, 4'hF, $urandom, v, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL map_unmapped_wr: got %b want 1", e); end
    access(0, 1, 0, 9'h024, 4'h0, 32'h0, v, e, lat);
    ref_read(0, 9'h024, xv, xe);
    n_cmp++; if (v !== xv || e !== xe) begin n_fail++; $display("FAIL map_idx9_rd: got %h/%b want %h/%b", v, e, xv, xe); end
    last_rd[0] = xv;
    n_cmp++; if (regs_o[0] !== exp_regs(0)) begin n_fail++; $display("FAIL map_regs: got %h want %h", regs_o[0], exp_regs(0)); end
  endtask

  task automatic test_both_strobes();
    logic [31:0] v, wd; bit e, xe; int lat;
    wd = $urandom;
    access(0, 1, 1, 9'h00C, 4'hF, wd, v, e, lat);
    ref_write(0, 9'h00C, 4'hF, wd, 1, xe);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL both_error: got %b want 1", e); end
    n_cmp++; if (v !== last_rd[0]) begin n_fail++; $display("FAIL both_rdata_hold: got %h want %h", v, last_rd[0]); end
    n_cmp++; if (regs_o[0][3*32 +: 32] !== wd) begin n_fail++; $display("FAIL both_write: got %h want %h", regs_o[0][3*32 +: 32], wd); end
  endtask

  task automatic test_wait_states();
    int first = -1;
    int hits = 0;
    logic [31:0] v = 32'h0;
    as_s[1] = 1'b1; rd_s[1] = 1'b1; addr[1] = 9'h000;
    @(posedge clk); #1;
    as_s[1] = 1'b0; rd_s[1] = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (rdy[1]) begin
        hits++;
        if (first < 0) begin first = cyc; v = rdat[1]; end
      end
      if (cyc == 2) begin
        as_s[1] = 1'b1; wr_s[1] = 1'b1; addr[1] = 9'h000; be[1] = 4'hF; wdat[1] = ~mdl[1][0];
      end
      if (cyc == 3) begin
        as_s[1] = 1'b0; wr_s[1] = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (first !== 4) begin n_fail++; $display("FAIL wait_latency: got cycle %0d want 4", first); end
    n_cmp++; if (hits !== 1) begin n_fail++; $display("FAIL wait_ready_count: got %0d want 1", hits); end
    n_cmp++; if (v !== mdl[1][0]) begin n_fail++; $display("FAIL wait_rd_data: got %h want %h", v, mdl[1][0]); end
    n_cmp++; if (regs_o[1] !== exp_regs(1)) begin n_fail++; $display("FAIL wait_ignored_wr: got %h want %h", regs_o[1], exp_regs(1)); end
    last_rd[1] = mdl[1][0];
  endtask

  task automatic test_reset_mid();
    int hits = 0;
    logic [31:0] v; bit e; int lat;
    as_s[1] = 1'b1; wr_s[1] = 1'b1; addr[1] = 9'h004; be[1] = 4'hF; wdat[1] = ~RV;
    @(posedge clk); #1;
    as_s[1] = 1'b0; wr_s[1] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (rdy[1]) hits++;
      @(posedge clk); #1;
    end
    n_cmp++; if (hits !== 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d pulses want 0", hits); end
    n_cmp++; if (regs_o[1] !== exp_regs(1)) begin n_fail++; $display("FAIL abort_regs: got %h want %h", regs_o[1], exp_regs(1)); end
    access(1, 1, 0, 9'h004, 4'h0, 32'h0, v, e, lat);
    n_cmp++; if (v !== RV || lat !== 4) begin n_fail++; $display("FAIL abort_rd: got %h lat %0d want %h lat 4", v, lat, RV); end
    last_rd[1] = RV;
  endtask

  task automatic test_random();
    logic [31:0] v, xv, wd; bit e, xe, r, w; int lat, kind, d;
    logic [6:0] idx; logic [3:0] b; logic [8:0] a;
    for (int it = 0; it < 120; it++) begin
      d = it & 1;
      status[d] = $urandom;
      idx  = 7'($urandom_range(0, 19));
      a    = {idx, 2'($urandom)};
      b    = 4'($urandom);
      wd   = $urandom;
      kind = $urandom_range(0, 9);
      r    = (kind < 4) || (kind == 9);
      w    = (kind >= 4);
      access(d, r, w, a, b, wd, v, e, lat);
      n_cmp++; if (lat !== ws(d) + 1) begin n_fail++; $display("FAIL rnd_latency it%0d: got %0d want %0d", it, lat, ws(d) + 1); end
      if (w) begin
        ref_write(d, a, b, wd, r, xe);
        n_cmp++; if (v !== last_rd[d]) begin n_fail++; $display("FAIL rnd_rdata_hold it%0d: got %h want %h", it, v, last_rd[d]); end
      end else begin
        ref_read(d, a, xv, xe);
        n_cmp++; if (v !== xv) begin n_fail++; $display("FAIL rnd_rdata it%0d addr %h: got %h want %h", it, a, v, xv); end
        last_rd[d] = xv;
      end
      n_cmp++; if (e !== xe) begin n_fail++; $display("FAIL rnd_error it%0d addr %h: got %b want %b", it, a, e, xe); end
      n_cmp++; if (regs_o[d] !== exp_regs(d)) begin n_fail++; $display("FAIL rnd_regs it%0d: got %h want %h", it, regs_o[d], exp_regs(d)); end
    end
  endtask

`ifdef MB_IO_SLAVE_REGS_IRQ_EN
  task automatic test_irq();
    logic [31:0] v, xv; bit e, xe; int lat;
    irq_src[0] = 32'h8;
    @(posedge clk); #1;
    irq_src[0] = 32'h0;
    istat[0] = istat[0] | 32'h8;
    access(0, 0, 1, 9'h028, 4'hF, 32'h8, v, e, lat);
    ref_write(0, 9'h028, 4'hF, 32'h8, 0, xe);
    @(posedge clk); #1;
    n_cmp++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b want 1", irq[0]); end
    access(0, 0, 1, 9'h024, 4'hF, 32'h8, v, e, lat);
    ref_write(0, 9'h024, 4'hF, 32'h8, 0, xe);
    n_cmp++; if (irq[0] !== |(istat[0] & ien[0] | 32'h8)) begin n_fail++; $display("FAIL irq_registered: got %b want 1", irq[0]); end
    @(posedge clk); #1;
    n_cmp++; if (irq[0] !== |(istat[0] & ien[0])) begin n_fail++; $display("FAIL irq_clear: got %b want %b", irq[0], |(istat[0] & ien[0])); end
    irq_src[0] = 32'h8;
    access(0, 0, 1, 9'h024, 4'hF, 32'h8, v, e, lat);
    irq_src[0] = 32'h0;
    ref_write(0, 9'h024, 4'hF, 32'h8, 0, xe);
    istat[0] = istat[0] | 32'h8;
    access(0, 1, 0, 9'h024, 4'h0, 32'h0, v, e, lat);
    ref_read(0, 9'h024, xv, xe);
    n_cmp++; if (v !== xv || v[3] !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %h want %h", v, xv); end
  endtask
`endif

  initial begin
    for (int d = 0; d < 2; d++) begin
      as_s[d] = 1'b0; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
      addr[d] = 9'h0; be[d] = 4'h0; wdat[d] = 32'h0; status[d] = $urandom;
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
      irq_src[d] = 32'h0;
`endif
    end
    test_reset();
    test_basic();
    test_byte_lanes();
    test_map();
    test_both_strobes();
    test_wait_states();
    test_reset_mid();
    test_random();
`ifdef MB_IO_SLAVE_REGS_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mb_io_slave_regs.md
MB_IO_SLAVE_REGS -- requirements
Module: mb_io_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, count of read/write registers (1..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, byte-address width; register index = IO_Address[ADDR_WIDTH-1:2].
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra cycles inserted before IO_Ready (0..15).
REQ-004 SHALL have parameter RESET_VALUE, default 32'h0, reset contents of every read/write register.
REQ-005 SHALL have ports: clk  input  1  sole clock, all logic rising-edge.
REQ-006 reset_n  input  1  reset; one clock; asynchronous, active-low.
REQ-007 IO_Addr_Strobe  input  1  address valid; IO_Read_Strobe  input  1  read request; IO_Write_Strobe  input  1  write request.
REQ-008 IO_Address  input  ADDR_WIDTH  byte address; IO_Byte_Enable  input  4  lane enables; IO_Write_Data  input  32  write data.
REQ-009 IO_Read_Data  output  32  registered read data; IO_Ready  output  1  one-cycle completion pulse.
REQ-010 io_error  output  1  one-cycle pulse, coincident with IO_Ready, on an erroneous access.
REQ-011 status_in  input  32  read-only status word; regs_out  output  NUM_REGS*32  flattened register contents, index 0 in LSBs.

Function
REQ-012 Map: index 0..NUM_REGS-1 read/write; index NUM_REGS read-only status_in; all others unmapped.
REQ-013 FSM states IDLE, WAIT, RESP; IDLE->WAIT on read or write strobe when WAIT_STATES>0, else IDLE->RESP.
REQ-014 WAIT loads a down-counter with WAIT_STATES-1 and moves to RESP when the counter reaches 0; RESP always returns to IDLE next cycle.
REQ-015 IO_Ready SHALL be 1 only in RESP; latency is WAIT_STATES+1 cycles after the strobe cycle.
REQ-016 Address, byte enables, write data and direction SHALL be captured in the strobe cycle; later input changes are ignored.
REQ-017 Writes commit on the clock edge leaving RESP; lane i updates bits [8i+7:8i] for each set IO_Byte_Enable[i]; any of the 16 enable combinations is legal.
REQ-018 Read data SHALL be sampled on entry to RESP and held in IO_Read_Data until the next read completes.
REQ-019 Strobes arriving outside IDLE SHALL be ignored.
REQ-020 Unmapped read returns 32'h0 with io_error; unmapped write or write to status index is discarded with io_error.
REQ-021 Simultaneous read and write strobes SHALL execute as write and assert io_error.
REQ-022 Write with IO_Byte_Enable=4'b0000 completes normally, changes nothing, no error.

Reset
REQ-023 On reset_n low: FSM IDLE, counter 0, IO_Ready 0, io_error 0, IO_Read_Data 0, registers RESET_VALUE, irq 0.
REQ-024 Reset mid-transaction SHALL abort it; no write commits, no IO_Ready emitted after release.

Configuration
REQ-025 Macro MB_IO_SLAVE_REGS_IRQ_EN defined: adds input irq_src 32, output irq 1, index NUM_REGS+1 IRQ status (write-1-to-clear, set by irq_src high each cycle, set wins over same-cycle clear) and index NUM_REGS+2 IRQ enable (read/write, reset 0).
REQ-026 With macro defined, irq SHALL be registered |(status & enable), one cycle after the status/enable change.
REQ-027 Macro undefined: no irq ports, indices NUM_REGS+1 and NUM_REGS+2 unmapped per REQ-020.

Structure
REQ-028 Package mb_io_slave_pkg SHALL hold FSM state typedef, status/IRQ index offsets, and lane-width constant.
REQ-029 Sub-module mb_io_byte_reg (32-bit register with per-lane enable and reset value) SHALL be instantiated per register via generate.

Verification
REQ-030 WAIT_STATES=0: write 32'hDEADBEEF, BE=4'hF, addr 0x04 -> IO_Ready 1 cycle later; read addr 0x04 -> 32'hDEADBEEF, io_error 0.
REQ-031 BE=4'b0101 write 32'h11223344 over 32'hFFFFFFFF at index 2 -> read 32'hFF22FF44.
REQ-032 WAIT_STATES=3: read strobe at cycle 0 -> IO_Ready exactly cycle 4; strobe at cycle 2 ignored.
REQ-033 NUM_REGS=8: read addr 0x20 -> status_in value; write 0x20 and read 0x40 -> io_error, read data 0, register contents unchanged.
REQ-034 reset_n low during WAIT of a write to index 1 -> no IO_Ready, index 1 reads RESET_VALUE.
REQ-035 IRQ_EN: irq_src bit 3 pulse, enable 32'h8 -> irq 1; write 32'h8 to status -> irq 0 next cycle; concurrent set and clear leaves bit set.
